// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the receiver and the future transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SCNT_W     = $clog2(OVERSAMPLE);
    localparam int START_MID  = 7;
    localparam int BIT_END    = 15;

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: a SYNC_STAGES flop synchronizer
// on the raw line, followed by a 3-sample majority filter that advances only
// on the oversample tick.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic rxd,
    output logic rxd_s,
    output logic maj
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             samp_q;

    // Move the asynchronous line into the clk domain; idle level is 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Take one filter sample of the synchronized line per oversample tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q <= 3'b111;
        end else if (tick) begin
            samp_q <= {samp_q[1:0], rxd_s};
        end
    end

    // 2-of-3 vote suppresses single-sample line glitches
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver for 8N1-style frames on a 16x oversample tick. Recovers
// LSB-first data, presents it on a valid/ready holding register, pulses
// frame_err on a bad stop bit and flags dropped bytes as a sticky overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rxd,
    input  logic                 rx_ready,
    input  logic                 ovr_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    logic rxd_s;
    logic maj;

    uart_state_e            state_q, state_d;
    logic [SCNT_W-1:0]      scnt_q, scnt_d;
    logic [2:0]             bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   deliver;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .rxd  (rxd),
        .rxd_s(rxd_s),
        .maj  (maj)
    );

    // Frame sequencing: start detect, mid-bit sampling, stop-bit check
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Start edge is looked for every clk so detection jitter is one clk, not one tick
                if (!rxd_s) begin
                    state_d = ST_START;
                    scnt_d  = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (scnt_q == SCNT_W'(START_MID)) begin
                        if (rxd_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            scnt_d  = '0;
                            bcnt_d  = '0;
                            state_d = ST_DATA;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    scnt_d = scnt_q + 1'b1;
                    if (scnt_q == SCNT_W'(BIT_END)) begin
                        shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == 3'(DATA_BITS - 1)) begin
                            state_d = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    scnt_d = scnt_q + 1'b1;
                    if (scnt_q == SCNT_W'(BIT_END)) begin
                        // Leave at stop-bit mid so the next start edge is caught with margin
                        if (maj) begin
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before another start is accepted
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: delivery, consumption and sticky overrun
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    // State, counters, shift register and holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with tick tied high (16 clk per bit).
// Frame index i counts negedges from the one that drives the start bit;
// outputs are sampled at each negedge before the next line value is driven.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .rxd      (rxd),
        .rx_ready (rx_ready),
        .ovr_clr  (ovr_clr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        int         exp_rise;
    } vec_t;

    vec_t vecs [5];

    int         rise_idx;
    int         ferr_cnt;
    int         ferr_idx;
    logic       busy_log [0:255];
    logic [7:0] snap_data;
    logic       snap_valid, snap_ferr, snap_ovr, snap_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one frame: start, 8 data bits LSB first, stop_len clk of stop level, tail of idle.
    // ready_idx/clr_idx/rst_idx/glitch_idx select per-index side stimulus (-1 = none).
    task automatic drive_frame(input logic [7:0] din, input int stop_len, input logic stop_lvl,
                               input int tail, input int ready_idx, input int clr_idx,
                               input int rst_idx, input int glitch_idx);
        logic prev;
        logic lvl;
        int   total;
        total    = 144 + stop_len + tail;
        rise_idx = -1;
        ferr_cnt = 0;
        ferr_idx = -1;
        prev     = rx_valid;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (rx_valid && !prev && rise_idx < 0) rise_idx = i;
            prev = rx_valid;
            if (frame_err) begin
                ferr_cnt++;
                ferr_idx = i;
            end
            busy_log[i] = busy;
            if (i < 16)                 lvl = 1'b0;
            else if (i < 144)           lvl = din[(i - 16) / 16];
            else if (i < 144 + stop_len) lvl = stop_lvl;
            else                        lvl = 1'b1;
            if (i == glitch_idx) lvl = ~lvl;
            rxd      = lvl;
            rx_ready = (i == ready_idx);
            ovr_clr  = (i == clr_idx);
            if (i == rst_idx) begin
                rst = 1'b0;
                #1;
                snap_data  = rx_data;
                snap_valid = rx_valid;
                snap_ferr  = frame_err;
                snap_ovr   = overrun;
                snap_busy  = busy;
            end
            if (rst_idx >= 0 && i == rst_idx + 3) rst = 1'b1;
        end
        rx_ready = 1'b0;
        ovr_clr  = 1'b0;
        rxd      = 1'b1;
    endtask

    task automatic consume();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{din: 8'hA5, exp_data: 8'hA5, exp_rise: 155};
        vecs[1] = '{din: 8'h00, exp_data: 8'h00, exp_rise: 155};
        vecs[2] = '{din: 8'hFF, exp_data: 8'hFF, exp_rise: 155};
        vecs[3] = '{din: 8'h81, exp_data: 8'h81, exp_rise: 155};
        vecs[4] = '{din: 8'h3C, exp_data: 8'h3C, exp_rise: 155};

        // Reset state
        idle(3);
        check("reset rx_data", 32'(rx_data), 0);
        check("reset rx_valid", 32'(rx_valid), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset overrun", 32'(overrun), 0);
        check("reset busy", 32'(busy), 0);
        rst = 1'b1;
        idle(4);

        // Table of clean frames, each consumed afterwards
        for (int v = 0; v < 5; v++) begin
            drive_frame(vecs[v].din, 16, 1'b1, 0, -1, -1, -1, -1);
            check("frame rise idx", 32'(rise_idx), 32'(vecs[v].exp_rise));
            check("frame rx_data", 32'(rx_data), 32'(vecs[v].exp_data));
            check("frame busy before stop-mid", 32'(busy_log[154]), 1);
            check("frame busy after stop-mid", 32'(busy_log[155]), 0);
            check("frame no frame_err", 32'(ferr_cnt), 0);
            consume();
            check("consume rx_valid", 32'(rx_valid), 0);
            check("consume rx_data held", 32'(rx_data), 32'(vecs[v].exp_data));
            idle(3);
        end

        // Start-bit glitch: 4 clk low, rejected at start-bit mid
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            busy_log[i] = busy;
            rxd = (i < 4) ? 1'b0 : 1'b1;
        end
        check("glitch busy idx2", 32'(busy_log[2]), 0);
        check("glitch busy idx3", 32'(busy_log[3]), 1);
        check("glitch busy idx10", 32'(busy_log[10]), 1);
        check("glitch busy idx11", 32'(busy_log[11]), 0);
        check("glitch rx_valid", 32'(rx_valid), 0);
        idle(4);

        // Bad stop bit, line held low 40 clk, then a clean 0x5A
        drive_frame(8'h00, 40, 1'b0, 16, -1, -1, -1, -1);
        check("ferr pulse count", 32'(ferr_cnt), 1);
        check("ferr pulse idx", 32'(ferr_idx), 155);
        check("ferr no valid", 32'(rise_idx), 32'(-1));
        check("ferr rx_valid", 32'(rx_valid), 0);
        check("ferr rx_data untouched", 32'(rx_data), 32'h3C);
        check("ferr no overrun", 32'(overrun), 0);
        check("break busy while low", 32'(busy_log[183]), 1);
        check("break busy after high", 32'(busy_log[199]), 0);
        drive_frame(8'h5A, 16, 1'b1, 0, -1, -1, -1, -1);
        check("after break rise", 32'(rise_idx), 155);
        check("after break data", 32'(rx_data), 32'h5A);
        consume();
        idle(3);

        // Overrun: two frames without consuming
        drive_frame(8'h11, 16, 1'b1, 0, -1, -1, -1, -1);
        drive_frame(8'h22, 16, 1'b1, 0, -1, -1, -1, -1);
        check("overrun data kept", 32'(rx_data), 32'h11);
        check("overrun valid", 32'(rx_valid), 1);
        check("overrun flag", 32'(overrun), 1);
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_clr flag", 32'(overrun), 0);
        check("ovr_clr data", 32'(rx_data), 32'h11);
        idle(2);

        // Consume and arrive in the same clk
        drive_frame(8'h22, 16, 1'b1, 0, 154, -1, -1, -1);
        check("simul data", 32'(rx_data), 32'h22);
        check("simul valid", 32'(rx_valid), 1);
        check("simul no overrun", 32'(overrun), 0);
        idle(2);

        // Overrun set and clear in the same clk: set wins
        drive_frame(8'h44, 16, 1'b1, 0, -1, 154, -1, -1);
        check("set-wins overrun", 32'(overrun), 1);
        check("set-wins data kept", 32'(rx_data), 32'h22);
        consume();
        check("set-wins consume", 32'(rx_valid), 0);
        idle(2);

        // Majority filter: one low sample at scnt==14 inside data bit 0 (a 1)
        drive_frame(8'hA5, 16, 1'b1, 0, -1, -1, -1, 23);
        check("majority rise", 32'(rise_idx), 155);
        check("majority data", 32'(rx_data), 32'hA5);
        idle(2);

        // Reset in the middle of data bit 3, with valid and overrun set beforehand
        drive_frame(8'hFF, 16, 1'b1, 0, -1, -1, 70, -1);
        check("mid-frame busy before rst", 32'(busy_log[69]), 1);
        check("rst rx_data", 32'(snap_data), 0);
        check("rst rx_valid", 32'(snap_valid), 0);
        check("rst frame_err", 32'(snap_ferr), 0);
        check("rst overrun", 32'(snap_ovr), 0);
        check("rst busy", 32'(snap_busy), 0);
        check("post-rst no partial byte", 32'(rise_idx), 32'(-1));
        check("post-rst rx_valid", 32'(rx_valid), 0);
        check("post-rst busy", 32'(busy), 0);
        idle(3);
        drive_frame(8'h3C, 16, 1'b1, 0, -1, -1, -1, -1);
        check("post-rst frame rise", 32'(rise_idx), 155);
        check("post-rst frame data", 32'(rx_data), 32'h3C);
        check("post-rst frame overrun", 32'(overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for 8N1-style serial frames. Sits directly downstream of the baud generator and consumes its 16x-oversample tick (OverTake) as `tick`. Recovers bytes from the asynchronous `rxd` line and presents them on a valid/ready holding register to the bus-side logic. Reports framing errors and overruns.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first; legal values 5..8.
SYNC_STAGES, 2, flip-flop stages on `rxd` before use; legal values 2..3.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
tick  input  1  16x-baud enable pulse from the baud generator. One clk wide. May be tied high (1 bit = 16 clk).
rxd  input  1  asynchronous serial line; idle level is 1.
rx_ready  input  1  consumer accepts `rx_data` on any clk where `rx_valid` and `rx_ready` are both 1.
ovr_clr  input  1  synchronous clear of `overrun`.
rx_data  output  DATA_BITS  last received byte; the holding register.
rx_valid  output  1  holding register is full.
frame_err  output  1  one-clk pulse when a bad stop bit is detected.
overrun  output  1  sticky flag: a completed byte was dropped because the holding register was full.
busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset values (asynchronous):
  - synchronizer flops = 1; state = IDLE; counters = 0.
  - rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0.
- Reset asserted mid-frame aborts the frame; no partial byte is ever presented.
- Synchronizer: `rxd_s` = `rxd` after SYNC_STAGES flops.
- Majority filter: a 3-bit shift register of `rxd_s`, advanced only on `tick`. `maj` = 2-of-3 vote.
- Counters: 4-bit `scnt` (tick counter within a bit) and 3-bit `bcnt` (bit index). Both advance only on `tick`; `scnt` wraps 15 -> 0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxd_s` == 0 (checked every clk, not gated by `tick`) -> START; scnt = 0. `tick` is otherwise ignored in IDLE.
  - START: on the tick where scnt == 7 (start-bit mid):
    - if `rxd_s` == 1 -> IDLE (glitch rejected);
    - else scnt = 0, bcnt = 0 -> DATA.
  - DATA: on the tick where scnt == 15:
    - shift `maj` in at the MSB of the shift register (LSB-first reception); bcnt++.
    - after bit DATA_BITS-1 -> STOP.
  - STOP: on the tick where scnt == 15:
    - `maj` == 1: deliver the byte and go to IDLE (half-bit early, for resync margin).
    - `maj` == 0: pulse frame_err for 1 clk, discard the byte, go to BREAK.
  - BREAK: stay until `rxd_s` == 1, then -> IDLE. This prevents a held-low line from re-triggering.
- Delivery, in the same clk as the STOP decision:
  - rx_valid == 0: load rx_data; rx_valid = 1 on the next clk.
  - rx_valid == 1 and rx_ready == 1 (simultaneous consume and arrive): load the new byte; rx_valid stays 1; no overrun.
  - rx_valid == 1 and rx_ready == 0: keep the old byte; overrun = 1.
- Consume: rx_valid & rx_ready with no delivery in that clk -> rx_valid = 0 on the next clk. rx_data holds its value.
- Overrun: cleared by ovr_clr. If a set and a clear happen in the same clk, set wins.
- Latency: rx_valid rises 1 clk after the stop-bit-mid tick, i.e. about 9.5 bit times after the start edge (8 data bits).
- Frame errors never set overrun and never modify rx_data.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (shared with the future uart_tx);
  - OVERSAMPLE = 16, START_MID = 7, BIT_END = 15.
- One sub-module, uart_rx_sync: the SYNC_STAGES synchronizer plus the tick-gated 3-sample majority filter. Outputs `rxd_s` and `maj`. The FSM, counters and holding register stay in uart_rx.

Test Plan:
1. tick = 1, frame 0xA5 (16 clk/bit) -> rx_data = 0xA5; rx_valid rises 1 clk after the stop-mid tick; frame_err = 0; busy drops at the same time.
2. rxd low for 4 ticks then high -> returns to IDLE at scnt == 7; rx_valid = 0; busy pulses only during that window.
3. Frame 0x00 with the line held low through the stop bit for 40 ticks -> frame_err 1-clk pulse; rx_valid = 0; busy = 1 until rxd rises; next frame 0x5A received correctly.
4. Back-to-back frames 0x11 then 0x22 with rx_ready = 0 -> rx_data = 0x11, overrun = 1; ovr_clr pulse -> overrun = 0; rx_data still 0x11.
5. rx_ready = 1 in exactly the clk that 0x22 completes while 0x11 is held -> rx_data = 0x22, rx_valid stays 1, overrun = 0.
6. Extra cases:
   - 1-tick low glitch at scnt == 14 inside a 1 data bit -> bit still 1 (majority).
   - rst low during DATA bit 3 -> all outputs reset.
   - After releasing rst, frame 0x3C received correctly.
